axil2amm: RTL and testbench

AXI4-Lite slave to Avalon-MM master bridge, single clock, one transaction in flight. It sits directly upstream of `amm2ahb_rv_dc`. It accepts AXI4-Lite reads and writes from the interconnect and issues them as Avalon-MM `read`/`write` commands honouring `waitrequest` and `readdatavalid`. It returns `bresp`/`rresp` to the AXI side.

---
 rtl/axil_pkg.sv | 18 +
 rtl/axil2amm_rr_arb2.sv | 26 ++
 rtl/axil2amm.sv | 176 +++++++++++++++++
 tb/tb_axil2amm.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_pkg.sv
// Shared types for the AXI4-Lite to Avalon-MM bridge: response codes and FSM states.
package axil_pkg;

  typedef enum logic [1:0] {
    AXIL_OKAY   = 2'b00,
    AXIL_SLVERR = 2'b10
  } axil_resp_t;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_CMD  = 3'd1,
    ST_WR_RESP = 3'd2,
    ST_RD_CMD  = 3'd3,
    ST_RD_WAIT = 3'd4,
    ST_RD_RESP = 3'd5
  } axil2amm_state_t;

endpackage

// File: rtl/axil2amm_rr_arb2.sv
// Two-request round-robin arbiter (write vs read); priority flag moves only on an accepted grant.
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req_wr,
  input  logic req_rd,
  input  logic accept,
  output logic gnt_wr,
  output logic gnt_rd
);

  logic last_was_read;

  // Flag resets to 1 so the first tie goes to the write side.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_was_read <= 1'b1;
    end else if (accept && (gnt_wr || gnt_rd)) begin
      last_was_read <= gnt_rd;
    end
  end

  assign gnt_wr = req_wr & (~req_rd | last_was_read);
  assign gnt_rd = req_rd & (~req_wr | ~last_was_read);

endmodule

// File: rtl/axil2amm.sv
// AXI4-Lite slave to Avalon-MM master bridge, one transaction in flight.
// Optional watchdog with SLVERR response enabled by defining AXIL2AMM_TIMEOUT_EN.
module axil2amm
  import axil_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic [2:0]            s_awprot,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic [2:0]            s_arprot,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic [ADDR_W-1:0]     amm_address,
  output logic [DATA_W-1:0]     amm_writedata,
  output logic [DATA_W/8-1:0]   amm_byteenable,
  output logic                  amm_write,
  output logic                  amm_read,
  input  logic [DATA_W-1:0]     amm_readdata,
  input  logic                  amm_readdatavalid,
  input  logic                  amm_waitrequest,
  output axil2amm_state_t       dbg_state
);

  // Handshakes: an AXI channel transfers on a cycle where valid and ready are both high;
  // ready here depends only on state and the competing valids, never on the *ready inputs.
  // AMM commands are held stable until a cycle with waitrequest low.

  localparam logic [ADDR_W-1:0] ADDR_MASK = ~ADDR_W'(3);

  axil2amm_state_t     state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W/8-1:0] be_q;
  logic [DATA_W-1:0]   rdata_q;
  axil_resp_t          resp_q;

  logic is_idle, gnt_wr, gnt_rd, rd_capture, timeout;

  wire unused_prot = ^{s_awprot, s_arprot};

  assign is_idle = (state_q == ST_IDLE);

  rr_arb2 u_arb (
    .clk    (aclk),
    .rst    (areset),
    .req_wr (is_idle & s_awvalid & s_wvalid),
    .req_rd (is_idle & s_arvalid),
    .accept (is_idle),
    .gnt_wr (gnt_wr),
    .gnt_rd (gnt_rd)
  );

`ifdef AXIL2AMM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q;

  // Counter is 0 in the first command cycle, so the command is driven for TIMEOUT_CYCLES cycles.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      cnt_q <= '0;
    end else if (is_idle) begin
      cnt_q <= '0;
    end else if (state_q == ST_WR_CMD || state_q == ST_RD_CMD || state_q == ST_RD_WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    rd_capture = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_wr)      state_d = (s_wstrb == '0) ? ST_WR_RESP : ST_WR_CMD;
        else if (gnt_rd) state_d = ST_RD_CMD;
      end
      ST_WR_CMD: begin
        if (!amm_waitrequest || timeout) state_d = ST_WR_RESP;
      end
      ST_WR_RESP: begin
        if (s_bready) state_d = ST_IDLE;
      end
      ST_RD_CMD: begin
        if (!amm_waitrequest) begin
          rd_capture = amm_readdatavalid;
          state_d    = amm_readdatavalid ? ST_RD_RESP : ST_RD_WAIT;
        end else if (timeout) begin
          state_d = ST_RD_RESP;
        end
      end
      ST_RD_WAIT: begin
        rd_capture = amm_readdatavalid;
        if (amm_readdatavalid || timeout) state_d = ST_RD_RESP;
      end
      ST_RD_RESP: begin
        if (s_rready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Command/response registers; a timeout without completion turns into SLVERR with zero data.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      rdata_q <= '0;
      resp_q  <= AXIL_OKAY;
    end else begin
      if (gnt_wr) begin
        addr_q  <= s_awaddr & ADDR_MASK;
        wdata_q <= s_wdata;
        be_q    <= s_wstrb;
        resp_q  <= AXIL_OKAY;
      end else if (gnt_rd) begin
        addr_q  <= s_araddr & ADDR_MASK;
        be_q    <= '1;
        resp_q  <= AXIL_OKAY;
      end
      if (rd_capture) begin
        rdata_q <= amm_readdata;
      end else if (timeout) begin
        if (state_q == ST_WR_CMD && amm_waitrequest) begin
          resp_q <= AXIL_SLVERR;
        end else if ((state_q == ST_RD_CMD && amm_waitrequest) || state_q == ST_RD_WAIT) begin
          resp_q  <= AXIL_SLVERR;
          rdata_q <= '0;
        end
      end
    end
  end

  assign s_awready      = gnt_wr;
  assign s_wready       = gnt_wr;
  assign s_arready      = gnt_rd;
  assign s_bvalid       = (state_q == ST_WR_RESP);
  assign s_rvalid       = (state_q == ST_RD_RESP);
  assign s_bresp        = resp_q;
  assign s_rresp        = resp_q;
  assign s_rdata        = rdata_q;
  assign amm_write      = (state_q == ST_WR_CMD);
  assign amm_read       = (state_q == ST_RD_CMD);
  assign amm_address    = addr_q;
  assign amm_writedata  = wdata_q;
  assign amm_byteenable = be_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_axil2amm.sv
// Directed self-checking bench for axil2amm; timeout scenario runs when AXIL2AMM_TIMEOUT_EN is defined.
module tb_axil2amm;
  import axil_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic [31:0] s_awaddr, s_wdata, s_araddr, amm_readdata;
  logic [3:0]  s_wstrb;
  logic [2:0]  s_awprot, s_arprot;
  logic        s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready;
  logic        amm_readdatavalid, amm_waitrequest;
  logic        s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]  s_bresp, s_rresp;
  logic [31:0] s_rdata, amm_address, amm_writedata;
  logic [3:0]  amm_byteenable;
  logic        amm_write, amm_read;
  axil2amm_state_t dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

  always #5 aclk = ~aclk;

  axil2amm #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(8)) dut (
    .aclk(aclk), .areset(areset),
    .s_awaddr(s_awaddr), .s_awprot(s_awprot), .s_awvalid(s_awvalid), .s_awready(s_awready),
    .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
    .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
    .s_araddr(s_araddr), .s_arprot(s_arprot), .s_arvalid(s_arvalid), .s_arready(s_arready),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
    .amm_address(amm_address), .amm_writedata(amm_writedata), .amm_byteenable(amm_byteenable),
    .amm_write(amm_write), .amm_read(amm_read),
    .amm_readdata(amm_readdata), .amm_readdatavalid(amm_readdatavalid),
    .amm_waitrequest(amm_waitrequest), .dbg_state(dbg_state)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_awready"}, s_awready, 0);
    check({tag, "_wready"}, s_wready, 0);
    check({tag, "_arready"}, s_arready, 0);
    check({tag, "_bvalid"}, s_bvalid, 0);
    check({tag, "_rvalid"}, s_rvalid, 0);
    check({tag, "_amm_write"}, amm_write, 0);
    check({tag, "_amm_read"}, amm_read, 0);
    check({tag, "_address"}, amm_address, 0);
    check({tag, "_writedata"}, amm_writedata, 0);
    check({tag, "_byteenable"}, amm_byteenable, 0);
    check({tag, "_rdata"}, s_rdata, 0);
    check({tag, "_bresp"}, s_bresp, 0);
    check({tag, "_rresp"}, s_rresp, 0);
  endtask

  initial begin
    int grants;
    int rd_cycles;
    logic [31:0] got;

    areset = 1'b1;
    s_awaddr = '0; s_wdata = '0; s_wstrb = '0; s_araddr = '0;
    s_awprot = '0; s_arprot = '0;
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0; s_bready = 1; s_rready = 1;
    amm_readdata = '0; amm_readdatavalid = 0; amm_waitrequest = 0;
    repeat (2) @(negedge aclk);
    check_all_zero("reset");
    next_cycle();
    areset = 1'b0;
    next_cycle();

    // Tie between write and read held for 4 transactions: W, R, W, R.
    exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(0); exp_q.push_back(1);
    s_awaddr = 32'h100; s_wdata = 32'h11; s_wstrb = 4'hF; s_awvalid = 1; s_wvalid = 1;
    s_araddr = 32'h200; s_arvalid = 1;
    amm_readdata = 32'hCAFE_0001; amm_readdatavalid = 1;
    grants = 0;
    for (int i = 0; i < 60 && grants < 4; i++) begin
      @(negedge aclk);
      if (s_awready || s_arready) begin
        got = s_arready ? 32'd1 : 32'd0;
        check("grant_order", got, exp_q.pop_front());
        check("grant_excl", s_awready & s_arready, 0);
        check("grant_aw_w", s_wready, s_awready);
        grants++;
      end
      next_cycle();
    end
    s_awvalid = 0; s_wvalid = 0; s_arvalid = 0;
    check("grant_count", grants, 4);
    @(negedge aclk);
    check("arb_amm_read", amm_read, 1);
    next_cycle();
    @(negedge aclk);
    check("arb_rvalid", s_rvalid, 1);
    check("arb_rdata", s_rdata, 32'hCAFE_0001);
    next_cycle();
    amm_readdatavalid = 0;
    next_cycle();

    // Single write, zero wait: amm_write at N+1, bvalid at N+2.
    s_awaddr = 32'h1000_0003; s_wdata = 32'hA5A5_5A5A; s_wstrb = 4'b1100;
    s_awvalid = 1; s_wvalid = 1;
    @(negedge aclk);
    check("wr_awready", s_awready, 1);
    check("wr_wready", s_wready, 1);
    next_cycle();
    s_awvalid = 0; s_wvalid = 0;
    @(negedge aclk);
    check("wr_amm_write", amm_write, 1);
    check("wr_address", amm_address, 32'h1000_0000);
    check("wr_byteenable", amm_byteenable, 4'b1100);
    check("wr_writedata", amm_writedata, 32'hA5A5_5A5A);
    check("wr_bvalid_early", s_bvalid, 0);
    next_cycle();
    @(negedge aclk);
    check("wr_amm_write_done", amm_write, 0);
    check("wr_bvalid", s_bvalid, 1);
    check("wr_bresp", s_bresp, AXIL_OKAY);
    next_cycle();
    @(negedge aclk);
    check("wr_bvalid_clear", s_bvalid, 0);
    next_cycle();

    // Read with 3 waitrequest cycles, data 2 cycles later, rready held low 5 cycles.
    s_rready = 0; s_araddr = 32'h20; s_arvalid = 1; amm_waitrequest = 1;
    @(negedge aclk);
    check("rd_arready", s_arready, 1);
    next_cycle();
    s_arvalid = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) amm_waitrequest = 0;
      @(negedge aclk);
      check("rd_amm_read", amm_read, 1);
      check("rd_address", amm_address, 32'h20);
      check("rd_byteenable", amm_byteenable, 4'hF);
      next_cycle();
    end
    @(negedge aclk);
    check("rd_wait_amm_read", amm_read, 0);
    next_cycle();
    amm_readdata = 32'h1234_5678; amm_readdatavalid = 1;
    @(negedge aclk);
    check("rd_wait_rvalid", s_rvalid, 0);
    next_cycle();
    amm_readdatavalid = 0; amm_readdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      @(negedge aclk);
      check("rd_rvalid_hold", s_rvalid, 1);
      check("rd_rdata_hold", s_rdata, 32'h1234_5678);
      check("rd_rresp", s_rresp, AXIL_OKAY);
      next_cycle();
    end
    s_rready = 1;
    @(negedge aclk);
    check("rd_rvalid_hs", s_rvalid, 1);
    next_cycle();
    @(negedge aclk);
    check("rd_rvalid_clear", s_rvalid, 0);
    next_cycle();

    // Zero-strobe write skips AMM.
    s_awaddr = 32'h40; s_wdata = 32'h55; s_wstrb = 4'b0000; s_awvalid = 1; s_wvalid = 1;
    @(negedge aclk);
    check("zs_awready", s_awready, 1);
    next_cycle();
    s_awvalid = 0; s_wvalid = 0;
    @(negedge aclk);
    check("zs_amm_write", amm_write, 0);
    check("zs_bvalid", s_bvalid, 1);
    check("zs_bresp", s_bresp, AXIL_OKAY);
    next_cycle();
    @(negedge aclk);
    check("zs_bvalid_clear", s_bvalid, 0);
    next_cycle();

    // Reset while in RD_WAIT; a later readdatavalid must be ignored.
    s_araddr = 32'h44; s_arvalid = 1;
    @(negedge aclk);
    check("rst_arready", s_arready, 1);
    next_cycle();
    s_arvalid = 0;
    next_cycle();
    @(negedge aclk);
    check("rst_in_wait", dbg_state, ST_RD_WAIT);
    areset = 1;
    @(negedge aclk);
    check_all_zero("rst_mid");
    next_cycle();
    areset = 0;
    amm_readdata = 32'h7777_7777; amm_readdatavalid = 1;
    @(negedge aclk);
    check("rst_late_rvalid", s_rvalid, 0);
    next_cycle();
    amm_readdatavalid = 0;
    @(negedge aclk);
    check("rst_late_rvalid2", s_rvalid, 0);
    check("rst_late_state", dbg_state, ST_IDLE);
    check("rst_late_rdata", s_rdata, 0);
    next_cycle();

`ifdef AXIL2AMM_TIMEOUT_EN
    // First give rdata a nonzero value, then stall a read until the watchdog fires.
    s_araddr = 32'h80; s_arvalid = 1; amm_readdata = 32'h0BAD_F00D; amm_readdatavalid = 1;
    next_cycle();
    s_arvalid = 0;
    next_cycle();
    amm_readdatavalid = 0;
    next_cycle();
    s_araddr = 32'h84; s_arvalid = 1; amm_waitrequest = 1;
    @(negedge aclk);
    check("to_arready", s_arready, 1);
    next_cycle();
    s_arvalid = 0;
    rd_cycles = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge aclk);
      if (!amm_read) break;
      rd_cycles++;
      next_cycle();
    end
    check("to_read_cycles", rd_cycles, 8);
    check("to_rvalid", s_rvalid, 1);
    check("to_rresp", s_rresp, AXIL_SLVERR);
    check("to_rdata", s_rdata, 0);
    next_cycle();
    amm_waitrequest = 0;
    next_cycle();
`else
    rd_cycles = 0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench time limit reached");
  end

endmodule
